aes_decrypt_iter: RTL and testbench

// - Iterative AES inverse cipher: one round per clock, valid/ready on input and output.
// - Receive side for ciphertext produced by the encrypt datapath.
// - Reuses keyExpansion, inverseShiftRows, inverseSubBytes and inverseMixColumns.
// - Round key i = fullKey[128*i +: 128] from keyExpansion.

---
 rtl/aes_decrypt_iter.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
//
// Iterative AES inverse cipher that processes one round per clock. It receives
// ciphertext from the encrypt datapath and returns the recovered plaintext.
// A 128-bit block and its cipher key are accepted with a valid/ready handshake.
// The plaintext is returned with a valid/ready handshake and is held until the
// downstream side accepts it.
//
// Parameters
//   N   block/state width in bits (128)
//   Nr  number of rounds (10)
//   Nk  key length in 32-bit words, used by the key expansion (4)
//
// Ports
//   clk        in   1      clock; all logic runs on posedge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      ct_in/key_in valid
//   in_ready   out  1      core can accept a block (high only in IDLE)
//   ct_in      in   N      ciphertext
//   key_in     in   32*Nk  cipher key
//   out_valid  out  1      pt_out valid
//   out_ready  in   1      downstream accepts pt_out
//   pt_out     out  N      recovered plaintext
//   busy       out  1      high in ROUND or DONE
//
// Optional feature, macro AES_DEC_EQCHK_EN
//   When the macro is defined, the block gains two ports:
//   exp_pt  in   N       expected plaintext, registered on accept
//   match   out  1       final plaintext == registered exp_pt; it is set when
//                        out_valid rises, held in DONE and cleared on return
//                        to IDLE.
//   When the macro is undefined, neither port exists and no comparator or
//   exp_pt register is built.
// -----------------------------------------------------------------------------
module aes_decrypt_iter #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    ct_in,
  input  logic [32*Nk-1:0] key_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    pt_out,
  output logic            busy
`ifdef AES_DEC_EQCHK_EN
  ,
  input  logic [N-1:0]    exp_pt,
  output logic            match
`endif
);

  localparam int NW = 4 * (Nr + 1);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and the S-box pair. The S-boxes are derived from the
  // field inverse and the affine map, so no lookup tables are needed.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // The inverse is x^254 = x^2 * x^4 * ... * x^128. This also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]}
             ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // ---------------------------------------------------------------------------
  // Key expansion. Round key i is placed at full_key[128*i +: 128]. Word w[4i]
  // is the most significant word of round key i.
  // ---------------------------------------------------------------------------
  function automatic logic [128*(Nr+1)-1:0] key_expansion(input logic [32*Nk-1:0] key);
    logic [31:0]            w [NW];
    logic [31:0]            t;
    logic [7:0]             rcon;
    logic [128*(Nr+1)-1:0]  fk;
    rcon = 8'h01;
    fk   = '0;
    for (int i = 0; i < NW; i++) begin
      if (i < Nk) begin
        w[i] = key[32*(Nk-i)-1 -: 32];
      end else begin
        t = w[i-1];
        if ((i % Nk) == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = xtime(rcon);
        end else if ((Nk > 6) && ((i % Nk) == 4)) begin
          t = sub_word(t);
        end
        w[i] = w[i-Nk] ^ t;
      end
      fk[128*(i/4) + 32*(3 - (i % 4)) +: 32] = w[i];
    end
    return fk;
  endfunction

  // ---------------------------------------------------------------------------
  // Inverse round transforms. Byte b of the state sits at bits
  // [127-8b -: 8]. The state is column-major, so byte (row r, column c) is
  // b = 4c + r.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  fsm_e             fsm_q, fsm_d;
  logic [N-1:0]     state_q, state_d;
  logic [N-1:0]     pt_q, pt_d;
  logic [32*Nk-1:0] key_q, key_d;
  logic [3:0]       rnd_q, rnd_d;
  logic             ov_q, ov_d;
`ifdef AES_DEC_EQCHK_EN
  logic [N-1:0]     exp_q, exp_d;
  logic             match_q, match_d;
`endif

  // In IDLE the expansion runs on key_in so that the initial AddRoundKey with
  // rk[Nr] can happen on the accepting edge. After that it runs on the held key.
  logic [32*Nk-1:0]        key_sel;
  logic [128*(Nr+1)-1:0]   full_key;
  logic [N-1:0]            rk_cur;
  logic [N-1:0]            rk_last;
  logic [N-1:0]            round_in;

  assign key_sel  = (fsm_q == S_IDLE) ? key_in : key_q;
  assign full_key = key_expansion(key_sel);
  assign rk_cur   = full_key[128*rnd_q +: 128];
  assign rk_last  = full_key[128*Nr +: 128];

  // Shared by the middle and final rounds. The final round omits InvMixColumns.
  assign round_in = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_cur;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    pt_d    = pt_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    ov_d    = ov_q;
`ifdef AES_DEC_EQCHK_EN
    exp_d   = exp_q;
    match_d = match_q;
`endif
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          key_d   = key_in;
          state_d = ct_in ^ rk_last;
          rnd_d   = 4'(Nr - 1);
          fsm_d   = S_ROUND;
`ifdef AES_DEC_EQCHK_EN
          exp_d   = exp_pt;
`endif
        end
      end
      S_ROUND: begin
        if (rnd_q != 4'd0) begin
          state_d = inv_mix_columns(round_in);
          rnd_d   = rnd_q - 4'd1;
        end else begin
          pt_d  = round_in;
          ov_d  = 1'b1;
          fsm_d = S_DONE;
`ifdef AES_DEC_EQCHK_EN
          match_d = (round_in == exp_q);
`endif
        end
      end
      S_DONE: begin
        if (ov_q && out_ready) begin
          ov_d  = 1'b0;
          fsm_d = S_IDLE;
`ifdef AES_DEC_EQCHK_EN
          match_d = 1'b0;
`endif
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      ov_q    <= 1'b0;
`ifdef AES_DEC_EQCHK_EN
      exp_q   <= '0;
      match_q <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      ov_q    <= ov_d;
`ifdef AES_DEC_EQCHK_EN
      exp_q   <= exp_d;
      match_q <= match_d;
`endif
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign busy      = (fsm_q == S_ROUND) || (fsm_q == S_DONE);
  assign out_valid = ov_q;
  assign pt_out    = pt_q;
`ifdef AES_DEC_EQCHK_EN
  assign match     = match_q;
`endif

endmodule

// File: tb/tb_aes_decrypt_iter.sv
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;
`ifdef AES_DEC_EQCHK_EN
  logic [127:0] exp_pt;
  logic         match;
`endif

  aes_decrypt_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
`ifdef AES_DEC_EQCHK_EN
    ,
    .exp_pt    (exp_pt),
    .match     (match)
`endif
  );

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [127:0] pt;
    int           acc;
    logic         m;
  } exp_t;
  exp_t sb[$];
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: compares every cycle out_valid is high against the head of the
  // scoreboard, and checks latency (and match) on the rising cycle.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid actual=1 required=0 pt_out=%h", pt_out);
        end else begin
          chk("pt_out", pt_out, sb[0].pt);
          if (!prev_ov) begin
            chk("latency", 128'(cyc - sb[0].acc), 128'd10);
`ifdef AES_DEC_EQCHK_EN
            chk("match", {127'b0, match}, {127'b0, sb[0].m});
`endif
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready && sb.size() > 0) sb.pop_front();
  end

  // Called at a negedge. It returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                      input logic [127:0] e, input logic m, input bit exp_out);
    bit ok;
    int acc;
    exp_t x;
    key_in   = k;
    ct_in    = c;
`ifdef AES_DEC_EQCHK_EN
    exp_pt   = e;
`endif
    in_valid = 1'b1;
    ok  = 1'b0;
    acc = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("accept_timeout", {127'b0, ok}, 128'd1);
    if (ok && exp_out) begin
      x.pt  = p;
      x.acc = acc;
      x.m   = m;
      sb.push_back(x);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 128'(sb.size()), 128'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ct_in     = '0;
    key_in    = '0;
`ifdef AES_DEC_EQCHK_EN
    exp_pt    = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_pt_out", pt_out, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_busy", {127'b0, busy}, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // App. B vector
    send(KB, CB, PB, PB, 1'b1, 1'b1);
    chk("busy_in_round", {127'b0, busy}, 128'd1);
    chk("in_ready_in_round", {127'b0, in_ready}, 128'd0);
    drain();
    chk("idle_in_ready", {127'b0, in_ready}, 128'd1);
    chk("idle_busy", {127'b0, busy}, 128'd0);

    // App. C.1 vector
    send(KC, CC, PC, PC, 1'b1, 1'b1);
    drain();

    // Output backpressure with a second block waiting
    out_ready = 1'b0;
    send(KB, CB, PB, PB, 1'b1, 1'b1);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("bp_out_valid_seen", {127'b0, out_valid}, 128'd1);
    key_in   = KC;
    ct_in    = CC;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
      chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
      chk("bp_pt_stable", pt_out, PB);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", {127'b0, in_ready}, 128'd1);
    chk("bp_release_out_valid", {127'b0, out_valid}, 128'd0);
    repeat (3) @(negedge clk);
    chk("bp_second_not_taken", {127'b0, busy}, 128'd0);
    drain();

    // Reset during ROUND, then a clean block
    send(KB, CB, PB, PB, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_out_valid", {127'b0, out_valid}, 128'd0);
    chk("abort_in_ready", {127'b0, in_ready}, 128'd1);
    chk("abort_busy", {127'b0, busy}, 128'd0);
    send(KB, CB, PB, PB, 1'b1, 1'b1);
    drain();
    repeat (12) @(negedge clk);

    // Key change mid-block
    send(KB, CB, PB, PB, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    key_in = '0;
    drain();

`ifdef AES_DEC_EQCHK_EN
    send(KB, CB, PB, PB, 1'b1, 1'b1);
    drain();
    chk("match_cleared", {127'b0, match}, 128'd0);
    send(KB, CB, PB, PB ^ 128'd1, 1'b0, 1'b1);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
